// File: rtl/minimips_regfile.sv
// ============================================================================
// minimips_regfile
// ----------------------------------------------------------------------------
// Purpose:
//   8 x DATA_W general-purpose register file for the MiniMIPS datapath. It has
//   two independent combinational read ports that feed the ALU operand path,
//   and one synchronous write port fed by the result mux. A pending-write
//   scoreboard tracks which registers are still waiting for write-back, so
//   issue logic can stall on them.
//
//   R0 is hard-wired to zero. Writes and reservations that target R0 are
//   dropped, and busy_vec[0] is always 0.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined   - write-to-read bypass. A read of the register being written
//               in this cycle returns wr_data. That port's busy flag reads 0,
//               unless the same register is also re-reserved in this cycle.
//   undefined - a same-cycle read returns the old register value. The busy
//               flags come only from the registered scoreboard.
//
// Parameters:
//   DATA_W     register width in bits (default 32)
//   NREG       number of registers, fixed at 8 (3-bit addresses)
//
// Ports:
//   clk        in   1       rising-edge clock
//   reset_n    in   1       asynchronous reset, active-low
//   rd_addr_a  in   3       read port A register index
//   rd_data_a  out  DATA_W  read port A data
//   rd_addr_b  in   3       read port B register index
//   rd_data_b  out  DATA_W  read port B data
//   wr_en      in   1       write strobe, sampled at clk rise
//   wr_addr    in   3       write register index
//   wr_data    in   DATA_W  write data
//   rsv_en     in   1       reserve strobe: mark rsv_addr as pending write
//   rsv_addr   in   3       register index to reserve
//   busy_a     out  1       register at rd_addr_a has a pending write
//   busy_b     out  1       register at rd_addr_b has a pending write
//   busy_vec   out  8       full scoreboard, bit i = register i pending
// ============================================================================
module minimips_regfile #(
    parameter int DATA_W = 32,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [2:0]        rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [2:0]        rsv_addr,
    output logic              busy_a,
    output logic              busy_b,
    output logic [NREG-1:0]   busy_vec
);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:1]   busyQ;       // R0 never has a pending write

    // ------------------------------------------------------------------------
    // Register array and scoreboard
    // ------------------------------------------------------------------------
    // NOTE: the array is reset explicitly because reset must make every read
    // return zero. Without this the array could map to a RAM macro, and that
    // RAM would keep its old contents through reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busyQ <= '0;
        end else begin
            // NOTE: all state updates use <=, so every branch samples the
            // values from before the edge, whatever order the statements are in.
            if (wr_en && (wr_addr != 3'd0)) begin
                regs[wr_addr] <= wr_data;
            end
            for (int i = 1; i < NREG; i++) begin
                // A new reservation takes priority over a clearing write-back
                // to the same register.
                if (rsv_en && (rsv_addr == 3'(i))) begin
                    busyQ[i] <= 1'b1;
                end else if (wr_en && (wr_addr == 3'(i))) begin
                    busyQ[i] <= 1'b0;
                end
            end
        end
    end

    assign busy_vec = {busyQ, 1'b0};

    // ------------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    // Bypass stays off during reset, because the pending write will be dropped.
    logic bypassWr;
    logic bypassBusy;
    assign bypassWr   = reset_n && wr_en && (wr_addr != 3'd0);
    assign bypassBusy = rsv_en && (rsv_addr == wr_addr);
`endif

    always_comb begin
        // NOTE: each output gets a default first, so every path assigns it
        // and no latch is inferred.
        rd_data_a = (rd_addr_a == 3'd0) ? '0 : regs[rd_addr_a];
        rd_data_b = (rd_addr_b == 3'd0) ? '0 : regs[rd_addr_b];
        busy_a    = busy_vec[rd_addr_a];
        busy_b    = busy_vec[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (bypassWr && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
            busy_a    = bypassBusy;
        end
        if (bypassWr && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
            busy_b    = bypassBusy;
        end
`endif
    end

endmodule
